// File: rtl/ternary_mm_sequencer.sv
// -----------------------------------------------------------------------------
// ternary_mm_sequencer
//
// Control sequencer for the ternary matrix-vector engine. It sits between the
// pin mux and the load/multiply datapaths. It decodes commands from the 16-bit
// input word and drives the weight-loader and multiplier enables, clear pulses
// and indices. It supports weight reload, single or continuous multiplies,
// abort, and a sticky error flag.
//
// Ports
//   clk        clock
//   rst_n      synchronous, active-low reset
//   in_word    {ui_in,uio_in}; [13:12] opcode, [11] continuous flag (IDLE only)
//   abort      synchronous abort, honoured in any state
//   load_en    loader captures in_word this cycle
//   load_clr   one-cycle pulse in the first LOAD cycle: clear weight shifter
//   mult_en    multiplier accumulates in_word this cycle
//   acc_clr    one-cycle pulse in the first ACC cycle: clear accumulators
//   out_valid  uo_out holds output element out_idx
//   in_idx     load word index (LOAD) or activation-pair index (ACC)
//   out_idx    output element being presented (DRAIN)
//   wt_valid   full weight matrix loaded
//   busy       sequencer not idle
//   err        sticky: multiply requested without valid weights
//   mult_cnt   completed multiply passes (saturating at 255)
//
// Optional feature macro: SEQ_PERF_CNT_EN
//   defined     -> mult_cnt is a live 8-bit saturating pass counter
//   not defined -> mult_cnt is tied to 8'h00 and no counter flops exist
// -----------------------------------------------------------------------------
module ternary_mm_sequencer #(
   parameter int MAX_IN_LEN  = 16,
   parameter int MAX_OUT_LEN = 8
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [15:0]                                   in_word,
   input  logic                                          abort,
   output logic                                          load_en,
   output logic                                          load_clr,
   output logic                                          mult_en,
   output logic                                          acc_clr,
   output logic                                          out_valid,
   output logic [$clog2(2*MAX_IN_LEN*MAX_OUT_LEN/16)-1:0] in_idx,
   output logic [$clog2(MAX_OUT_LEN)-1:0]                out_idx,
   output logic                                          wt_valid,
   output logic                                          busy,
   output logic                                          err,
   output logic [7:0]                                    mult_cnt
);

   localparam int LOAD_WORDS = 2 * MAX_IN_LEN * MAX_OUT_LEN / 16;
   localparam int ACC_CYC    = MAX_IN_LEN / 2;
   localparam int IN_W       = $clog2(LOAD_WORDS);
   localparam int OUT_W      = $clog2(MAX_OUT_LEN);

   localparam logic [IN_W-1:0]  LOAD_LAST = IN_W'(LOAD_WORDS - 1);
   localparam logic [IN_W-1:0]  ACC_LAST  = IN_W'(ACC_CYC - 1);
   localparam logic [OUT_W-1:0] OUT_LAST  = OUT_W'(MAX_OUT_LEN - 1);

   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_MULT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_LOAD  = 2'b01,
      S_ACC   = 2'b10,
      S_DRAIN = 2'b11
   } state_t;

   state_t           state;
   logic [IN_W-1:0]  in_cnt;
   logic [OUT_W-1:0] out_cnt;
   logic             cont;
   logic             wt_valid_q;
   logic             err_q;

   // Only the opcode and continuous-flag bits steer the sequencer; the rest of
   // the word is datapath payload.
   logic unused_payload;
   assign unused_payload = ^{in_word[15:14], in_word[10:0]};

   // Main sequencer. Abort is checked before the per-state logic so that it
   // wins over any last-word / last-output transition in the same cycle.
   // Counters are zeroed on every state change, so the first cycle of each
   // state always sees index 0 and the clear pulses fall out of that.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         in_cnt     <= '0;
         out_cnt    <= '0;
         cont       <= 1'b0;
         wt_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else if (abort) begin
         state   <= S_IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
         cont    <= 1'b0;
         if (state == S_LOAD) begin
            wt_valid_q <= 1'b0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               in_cnt  <= '0;
               out_cnt <= '0;
               if (in_word[13:12] == OP_LOAD) begin
                  state      <= S_LOAD;
                  wt_valid_q <= 1'b0;
               end else if (in_word[13:12] == OP_MULT) begin
                  if (wt_valid_q) begin
                     state <= S_ACC;
                     cont  <= in_word[11];
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (in_cnt == LOAD_LAST) begin
                  state      <= S_IDLE;
                  in_cnt     <= '0;
                  wt_valid_q <= 1'b1;
                  err_q      <= 1'b0;
               end else begin
                  in_cnt <= in_cnt + 1'b1;
               end
            end
            S_ACC: begin
               if (in_cnt == ACC_LAST) begin
                  state   <= S_DRAIN;
                  in_cnt  <= '0;
                  out_cnt <= '0;
               end else begin
                  in_cnt <= in_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (out_cnt == OUT_LAST) begin
                  state   <= cont ? S_ACC : S_IDLE;
                  in_cnt  <= '0;
                  out_cnt <= '0;
               end else begin
                  out_cnt <= out_cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               in_cnt  <= '0;
               out_cnt <= '0;
               cont    <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEQ_PERF_CNT_EN
   // Pass counter: bumps when the last output element leaves DRAIN without an
   // abort in the same cycle, and holds at 255.
   logic       drain_done;
   logic [7:0] mult_cnt_q;

   assign drain_done = (state == S_DRAIN) && (out_cnt == OUT_LAST) && !abort;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mult_cnt_q <= 8'h00;
      end else if (drain_done && (mult_cnt_q != 8'hFF)) begin
         mult_cnt_q <= mult_cnt_q + 8'd1;
      end
   end

   assign mult_cnt = mult_cnt_q;
`else
   assign mult_cnt = 8'h00;
`endif

   // Outputs are decoded from the registered state and counters only, so they
   // change cleanly on the clock edge and never depend on in_word directly.
   assign load_en   = (state == S_LOAD);
   assign load_clr  = (state == S_LOAD) && (in_cnt == '0);
   assign mult_en   = (state == S_ACC);
   assign acc_clr   = (state == S_ACC) && (in_cnt == '0);
   assign out_valid = (state == S_DRAIN);
   assign in_idx    = in_cnt;
   assign out_idx   = out_cnt;
   assign wt_valid  = wt_valid_q;
   assign busy      = (state != S_IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_ternary_mm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ternary_mm_sequencer
//
// Self-checking bench for ternary_mm_sequencer. Each scenario task plans a
// list of cycles: the inputs to apply and the full output vector expected
// after the following clock edge. These go into a scoreboard queue. The task
// then replays the queue and compares every output vector against its planned
// value.
// -----------------------------------------------------------------------------
module tb_ternary_mm_sequencer;

`ifdef SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] in_word;
   logic        abort;
   logic        load_en;
   logic        load_clr;
   logic        mult_en;
   logic        acc_clr;
   logic        out_valid;
   logic [3:0]  in_idx;
   logic [2:0]  out_idx;
   logic        wt_valid;
   logic        busy;
   logic        err;
   logic [7:0]  mult_cnt;

   ternary_mm_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_word   (in_word),
      .abort     (abort),
      .load_en   (load_en),
      .load_clr  (load_clr),
      .mult_en   (mult_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .in_idx    (in_idx),
      .out_idx   (out_idx),
      .wt_valid  (wt_valid),
      .busy      (busy),
      .err       (err),
      .mult_cnt  (mult_cnt)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One packed view of every output so a cycle is one comparison.
   // {load_en,load_clr,mult_en,acc_clr,out_valid,in_idx,out_idx,wt_valid,busy,err,mult_cnt}
   logic [22:0] obs;
   assign obs = {load_en, load_clr, mult_en, acc_clr, out_valid, in_idx, out_idx,
                 wt_valid, busy, err, mult_cnt};

   typedef struct {
      logic [15:0] w;
      logic        ab;
      logic        rn;
      logic [22:0] exp;
   } cyc_t;

   cyc_t sb[$];

   int checks = 0;
   int errors = 0;

   // Expected-state bookkeeping carried between scenarios.
   logic       exp_wv  = 1'b0;
   logic       exp_err = 1'b0;
   logic [7:0] exp_mc  = 8'h00;

   function automatic logic [22:0] mk(input logic le, input logic lc, input logic me,
                                      input logic ac, input logic ov, input logic [3:0] ii,
                                      input logic [2:0] oi, input logic wv, input logic b,
                                      input logic e, input logic [7:0] mc);
      return {le, lc, me, ac, ov, ii, oi, wv, b, e, mc};
   endfunction

   function automatic void plan(input logic [15:0] w, input logic ab, input logic rn,
                                input logic [22:0] exp);
      cyc_t c;
      c.w   = w;
      c.ab  = ab;
      c.rn  = rn;
      c.exp = exp;
      sb.push_back(c);
   endfunction

   function automatic logic [22:0] idle_exp();
      return mk(0, 0, 0, 0, 0, 4'd0, 3'd0, exp_wv, 0, exp_err, exp_mc);
   endfunction

   // Reset asserted with a command on the bus, then released: everything zero.
   task automatic test_reset();
      cyc_t c;
      int   n = 0;
      exp_wv  = 1'b0;
      exp_err = 1'b0;
      exp_mc  = 8'h00;
      plan(16'h3800, 1'b0, 1'b0, 23'd0);
      plan(16'h2000, 1'b0, 1'b0, 23'd0);
      plan(16'h0000, 1'b0, 1'b1, 23'd0);
      plan(16'h1000, 1'b0, 1'b1, 23'd0);
      while (sb.size() > 0) begin
         c = sb.pop_front();
         in_word = c.w; abort = c.ab; rst_n = c.rn;
         @(posedge clk); #1;
         checks++;
         if (obs !== c.exp) begin
            errors++;
            $display("[TB] FAIL reset cyc=%0d got=%h exp=%h", n, obs, c.exp);
         end
         n++;
      end
   endtask

   // MULT with no weights: err sets, sequencer stays idle; abort in IDLE keeps err.
   task automatic test_err_no_weights();
      cyc_t c;
      int   n = 0;
      exp_err = 1'b1;
      plan(16'h3000, 1'b0, 1'b1, idle_exp());
      plan(16'h0000, 1'b0, 1'b1, idle_exp());
      plan(16'h3800, 1'b1, 1'b1, idle_exp());
      while (sb.size() > 0) begin
         c = sb.pop_front();
         in_word = c.w; abort = c.ab; rst_n = c.rn;
         @(posedge clk); #1;
         checks++;
         if (obs !== c.exp) begin
            errors++;
            $display("[TB] FAIL err_no_weights cyc=%0d got=%h exp=%h", n, obs, c.exp);
         end
         n++;
      end
   endtask

   // Full weight load; optionally abort while the last word is presented.
   task automatic test_load(input bit abort_last, input string name);
      cyc_t c;
      int   n = 0;
      exp_wv = 1'b0;
      plan(16'h2000, 1'b0, 1'b1, mk(1, 1, 0, 0, 0, 4'd0, 3'd0, 0, 1, exp_err, exp_mc));
      for (int i = 1; i < 16; i++) begin
         plan(16'($urandom), 1'b0, 1'b1,
              mk(1, 0, 0, 0, 0, 4'(i), 3'd0, 0, 1, exp_err, exp_mc));
      end
      if (!abort_last) begin
         exp_wv  = 1'b1;
         exp_err = 1'b0;
      end
      plan(16'h0000, abort_last, 1'b1, idle_exp());
      plan(16'h0000, 1'b0, 1'b1, idle_exp());
      while (sb.size() > 0) begin
         c = sb.pop_front();
         in_word = c.w; abort = c.ab; rst_n = c.rn;
         @(posedge clk); #1;
         checks++;
         if (obs !== c.exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, n, obs, c.exp);
         end
         n++;
      end
   endtask

   // Multiply passes. Abort is applied after DRAIN element abort_idx of pass
   // abort_pass (use a negative pass to never abort).
   task automatic test_mult(input bit cont, input int passes, input int abort_pass,
                            input int abort_idx, input string name);
      cyc_t        c;
      int          n = 0;
      bit          done = 1'b0;
      logic [15:0] w;
      w = cont ? 16'h3800 : 16'h3000;
      for (int p = 0; p < passes && !done; p++) begin
         for (int i = 0; i < 8; i++) begin
            plan(w, 1'b0, 1'b1,
                 mk(0, 0, 1, (i == 0), 0, 4'(i), 3'd0, 1, 1, exp_err, exp_mc));
            w = 16'($urandom);
         end
         for (int j = 0; j < 8 && !done; j++) begin
            plan(w, 1'b0, 1'b1,
                 mk(0, 0, 0, 0, 1, 4'd0, 3'(j), 1, 1, exp_err, exp_mc));
            w = 16'($urandom) & 16'hCFFF;
            if (p == abort_pass && j == abort_idx) begin
               plan(16'h0000, 1'b1, 1'b1, idle_exp());
               done = 1'b1;
            end
         end
         if (!done && PERF && exp_mc != 8'hFF) begin
            exp_mc = exp_mc + 8'd1;
         end
      end
      if (!done) begin
         plan(16'h0000, 1'b0, 1'b1, idle_exp());
      end
      plan(16'h0000, 1'b0, 1'b1, idle_exp());
      while (sb.size() > 0) begin
         c = sb.pop_front();
         in_word = c.w; abort = c.ab; rst_n = c.rn;
         @(posedge clk); #1;
         checks++;
         if (obs !== c.exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, n, obs, c.exp);
         end
         n++;
      end
   endtask

   // Reset dropped in the middle of ACC: all outputs back to zero next cycle.
   task automatic test_reset_mid_acc();
      cyc_t c;
      int   n = 0;
      plan(16'h3000, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 4'd0, 3'd0, 1, 1, exp_err, exp_mc));
      plan(16'hFFFF, 1'b0, 1'b1, mk(0, 0, 1, 0, 0, 4'd1, 3'd0, 1, 1, exp_err, exp_mc));
      plan(16'h1234, 1'b0, 1'b1, mk(0, 0, 1, 0, 0, 4'd2, 3'd0, 1, 1, exp_err, exp_mc));
      exp_wv  = 1'b0;
      exp_err = 1'b0;
      exp_mc  = 8'h00;
      plan(16'h3800, 1'b0, 1'b0, 23'd0);
      plan(16'h0000, 1'b0, 1'b1, 23'd0);
      while (sb.size() > 0) begin
         c = sb.pop_front();
         in_word = c.w; abort = c.ab; rst_n = c.rn;
         @(posedge clk); #1;
         checks++;
         if (obs !== c.exp) begin
            errors++;
            $display("[TB] FAIL reset_mid_acc cyc=%0d got=%h exp=%h", n, obs, c.exp);
         end
         n++;
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      in_word = 16'h0000;
      abort   = 1'b0;
      #1;
      test_reset();
      test_err_no_weights();
      test_load(1'b1, "load_abort_last");
      test_load(1'b0, "load_full");
      test_mult(1'b0, 1, -1, 0, "mult_single");
      test_mult(1'b0, 1, -1, 0, "mult_back_to_back");
      test_mult(1'b1, 3, 2, 3, "mult_cont_abort_drain");
      test_mult(1'b1, 1, 0, 7, "mult_cont_abort_last_out");
      test_mult(1'b1, 260, 259, 0, "mult_cont_saturate");
      test_reset_mid_acc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
